// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared types and constants for the SPI register-write responder.
//   state_t    : frame state machine encoding (IDLE, SHIFT, DONE)
//   FRAME_BITS : bits in one valid write frame
//   ADDR_W     : register address width
//   DATA_W     : register data width
//   CNT_W      : bit counter width, wide enough to hold the saturation value
// -----------------------------------------------------------------------------
package spi_slave_pkg;

    localparam int FRAME_BITS = 32;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    // Counter landmarks: a complete frame, and the saturation value that
    // marks "too many bits".
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(8);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// N-stage pin synchronizer followed by one edge-detect register.
//   clk40M : system clock
//   rst    : asynchronous active-high reset
//   i_pin  : asynchronous input pin
//   o_rise : one-cycle pulse on a synchronized 0->1 transition
//   o_fall : one-cycle pulse on a synchronized 1->0 transition
// Both pulses are visible STAGES cycles after the pin moves and are acted on
// at the following clock edge.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk40M,
    input  logic rst,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    // Everything resets to 0: a pin already low at reset release then shows
    // no falling edge, so a frame in progress is never picked up halfway.
    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= w_level;
        end
    end

    assign w_level = r_sync[STAGES-1];
    assign o_rise  =  w_level & ~r_prev;
    assign o_fall  = ~w_level &  r_prev;

endmodule

// File: rtl/spi_slave_regif.sv
// -----------------------------------------------------------------------------
// spi_slave_regif
// SPI mode-3, LSB-first responder for 4-byte register-write frames
// (address LSB, address MSB, data LSB, data MSB), oversampled by clk40M.
//   clk40M     : system clock
//   rst        : asynchronous active-high reset
//   spi_clk    : SPI clock, idles high
//   sl         : chip select, active low, one frame per assertion
//   mosi       : serial data from the master
//   miso       : serial data to the master (echo of the previous byte when
//                SPI_SLAVE_MISO_ECHO_EN is defined, otherwise constant 0)
//   o_wrEn     : one-cycle write strobe for a 32-bit frame
//   o_addr     : write address, held until the next o_wrEn
//   o_data     : write data, held until the next o_wrEn
//   o_frameErr : one-cycle pulse when a frame had the wrong bit count
// Optional feature macro: SPI_SLAVE_MISO_ECHO_EN
// -----------------------------------------------------------------------------
module spi_slave_regif
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk40M,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              sl,
    input  logic              mosi,
    output logic              miso,
    output logic              o_wrEn,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_frameErr
);

    logic                   w_sck_rise, w_sck_fall;
    logic                   w_sl_rise, w_sl_fall;
    logic                   w_mosi;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    state_t                 r_state, w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME_BITS-1:0]  r_sr;
    logic                   w_cnt_clr, w_shift_en, w_frame_ok, w_frame_bad;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk40M (clk40M),
        .rst    (rst),
        .i_pin  (spi_clk),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sl_sync (
        .clk40M (clk40M),
        .rst    (rst),
        .i_pin  (sl),
        .o_rise (w_sl_rise),
        .o_fall (w_sl_fall)
    );

    // mosi has the same depth as spi_clk, so data and clock stay aligned.
    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // NOTE: non-blocking assignments on every flop so all registers sample
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_frame_ok   = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sl_fall) begin
                    w_next_state = SHIFT;
                    w_cnt_clr    = 1'b1;
                end
            end
            SHIFT: begin
                w_shift_en = w_sck_rise;
                if (w_sl_rise) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_frame_ok  = (r_cnt == CNT_FULL);
                w_frame_bad = (r_cnt != CNT_FULL);
                // A new frame may start while the previous one is judged.
                if (w_sl_fall) begin
                    w_next_state = SHIFT;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_sr       <= '0;
            o_wrEn     <= 1'b0;
            o_frameErr <= 1'b0;
            o_addr     <= '0;
            o_data     <= '0;
        end else begin
            o_wrEn     <= 1'b0;
            o_frameErr <= 1'b0;

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_shift_en) begin
                // Bits past the frame length only push the counter to its
                // saturation value; the captured frame is left untouched.
                if (r_cnt < CNT_FULL) begin
                    r_sr <= {w_mosi, r_sr[FRAME_BITS-1:1]};
                end
                if (r_cnt != CNT_SAT) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if (w_frame_ok) begin
                o_addr <= r_sr[ADDR_W-1:0];
                o_data <= r_sr[FRAME_BITS-1:ADDR_W];
                o_wrEn <= 1'b1;
            end
            if (w_frame_bad) begin
                o_frameErr <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_MISO_ECHO_EN
    logic [7:0] r_echo;

    // miso replays the previous byte, one byte behind the master. On a byte
    // boundary the byte just completed sits in the top 8 bits of r_sr.
    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            r_echo <= '0;
            miso   <= 1'b0;
        end else if (r_state != SHIFT) begin
            miso <= 1'b0;
        end else if (w_sck_fall) begin
            if (r_cnt < CNT_BYTE) begin
                miso <= 1'b0;
            end else if (r_cnt[2:0] == 3'd0) begin
                r_echo <= r_sr[FRAME_BITS-1:FRAME_BITS-8];
                miso   <= r_sr[FRAME_BITS-8];
            end else begin
                miso <= r_echo[r_cnt[2:0]];
            end
        end
    end
`else
    // Without echo the falling-edge detect has no consumer.
    logic w_unused_sck_fall;
    assign w_unused_sck_fall = w_sck_fall;
    assign miso              = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_regif.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_regif
// Drives mode-3 LSB-first frames into spi_slave_regif and compares strobes,
// held address/data, strobe latency and miso against a frame-level model:
// a frame of exactly 32 bits is a write of {bits[31:16], bits[15:0]}, any
// other length is one error pulse, and miso replays the byte sent 8 bits
// earlier when SPI_SLAVE_MISO_ECHO_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_regif;

    logic        clk40M  = 1'b0;
    logic        rst     = 1'b1;
    logic        spi_clk = 1'b1;
    logic        sl      = 1'b1;
    logic        mosi    = 1'b0;
    logic        miso;
    logic        o_wrEn;
    logic [15:0] o_addr;
    logic [15:0] o_data;
    logic        o_frameErr;

    spi_slave_regif #(.SYNC_STAGES(2)) dut (
        .clk40M     (clk40M),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .sl         (sl),
        .mosi       (mosi),
        .miso       (miso),
        .o_wrEn     (o_wrEn),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .o_frameErr (o_frameErr)
    );

    always #12.5 clk40M = ~clk40M;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [15:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic [31:0] exp_q[$];
    int          exp_err = 0;

    // Observed strobes
    logic [31:0] got_q[$];
    int          err_seen = 0;
    int          cyc      = 0;
    int          t_rise   = 0;
    logic        prev_wr  = 1'b0;
    logic        prev_err = 1'b0;

    always @(posedge clk40M) cyc <= cyc + 1;

    always @(negedge clk40M) begin
        if (o_wrEn) begin
            got_q.push_back({o_addr, o_data});
            check("wr_latency", cyc - t_rise, 4);
            check("wr_width", {31'd0, prev_wr}, 0);
        end
        if (o_frameErr) begin
            err_seen <= err_seen + 1;
            check("err_latency", cyc - t_rise, 4);
            check("err_width", {31'd0, prev_err}, 0);
        end
        prev_wr  <= o_wrEn;
        prev_err <= o_frameErr;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk40M);
    endtask

    task automatic model_frame(input logic [63:0] bits, input int nbits);
        if (nbits == 32) begin
            m_addr = bits[15:0];
            m_data = bits[31:16];
            exp_q.push_back({m_addr, m_data});
        end else begin
            exp_err++;
        end
    endtask

    // One chip-select assertion of nbits bits. rst_bit >= 0 pulses reset
    // after that many bits and keeps clocking with sl still low.
    task automatic spi_frame(input logic [63:0] bits, input int nbits, input int half,
                             input int gap, input int rst_bit);
        logic exp_m;
        sl = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b0;
            mosi    = bits[i];
            wait_clk(half);
`ifdef SPI_SLAVE_MISO_ECHO_EN
            exp_m = (i < 8) ? 1'b0 : bits[i-8];
`else
            exp_m = 1'b0;
`endif
            if (rst_bit < 0) check($sformatf("miso_bit%0d", i), {31'd0, miso}, {31'd0, exp_m});
            spi_clk = 1'b1;
            wait_clk(half);
            if (i + 1 == rst_bit) begin
                rst = 1'b1;
                m_addr = '0;
                m_data = '0;
                wait_clk(3);
                rst = 1'b0;
                wait_clk(2);
            end
        end
        sl     = 1'b1;
        t_rise = cyc;
        mosi   = 1'b0;
        wait_clk(gap);
    endtask

    task automatic verify(input string tag);
        int n;
        logic [31:0] g, e;
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_wr"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, "_nerr"}, err_seen, exp_err);
        check({tag, "_addr"}, {16'd0, o_addr}, {16'd0, m_addr});
        check({tag, "_data"}, {16'd0, o_data}, {16'd0, m_data});
        check({tag, "_miso_idle"}, {31'd0, miso}, 0);
    endtask

    task automatic run_frame(input string tag, input logic [63:0] bits, input int nbits,
                             input int half, input int gap);
        model_frame(bits, nbits);
        spi_frame(bits, nbits, half, gap, -1);
        if (gap > 1) verify(tag);
    endtask

    initial begin
        logic [63:0] rb;
        int          nb, hp, gp;

        wait_clk(4);
        check("rst_miso",  {31'd0, miso}, 0);
        check("rst_wrEn",  {31'd0, o_wrEn}, 0);
        check("rst_err",   {31'd0, o_frameErr}, 0);
        check("rst_addr",  {16'd0, o_addr}, 0);
        check("rst_data",  {16'd0, o_data}, 0);
        rst = 1'b0;
        wait_clk(6);
        verify("post_rst");

        // Bytes F9 00 07 C0 -> address 0x00F9, data 0xC007
        run_frame("valid", 64'h0000_0000_C007_00F9, 32, 8, 10);
        run_frame("short", 64'h0000_0000_00AB_CDEF, 24, 8, 10);
        run_frame("long",  64'h0000_0001_1234_5678, 33, 8, 10);

        // Back-to-back, sl high for one SPI half-period
        run_frame("b2b_a", 64'h0000_0000_0001_0030, 32, 8, 8);
        run_frame("b2b_b", 64'h0000_0000_0001_0031, 32, 8, 10);

        // Back-to-back with sl high for a single system clock
        run_frame("tight_a", 64'h0000_0000_BEEF_1234, 32, 6, 1);
        run_frame("tight_b", 64'h0000_0000_5A5A_0042, 32, 6, 10);

        // Reset after 16 bits, frame completes with sl low: no strobes
        spi_frame(64'h0000_0000_DEAD_0077, 32, 8, 10, 16);
        verify("rst_mid");
        run_frame("after_rst", 64'h0000_0000_0000_0038, 32, 8, 10);

        // Echo pattern A5 3C 00 00
        run_frame("echo", 64'h0000_0000_0000_3CA5, 32, 8, 10);

        for (int r = 0; r < 30; r++) begin
            rb = {$urandom, $urandom};
            nb = ($urandom_range(0, 2) != 0) ? 32 : int'($urandom_range(20, 33));
            hp = $urandom_range(4, 10);
            gp = ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(6, 12));
            run_frame($sformatf("rnd%0d", r), rb, nb, hp, gp);
        end
        run_frame("final", 64'h0000_0000_0F0F_F0F0, 32, 4, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
